// File: rtl/bcd_adder.sv
// Single-digit BCD adder: A + B + Cin with decimal correction, plus a non-BCD operand flag.
// Latency 1 cycle; Sum/Cout/err are all registered together.
// No backpressure: a new result is captured on every clock.
module bcd_adder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       err
);

    logic [4:0] bin_sum;
    logic [4:0] adj_sum;
    logic [3:0] sum_d, sum_q;
    logic       cout_d, cout_q;
    logic       err_d, err_q;

    always_comb begin
        bin_sum = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
        // Adding 6 skips the six unused codes 10..15; only the low nibble is kept.
        adj_sum = bin_sum + 5'd6;
        sum_d   = bin_sum[3:0];
        cout_d  = 1'b0;
        if (bin_sum > 5'd9) begin
            sum_d  = adj_sum[3:0];
            cout_d = 1'b1;
        end
        err_d = (A > 4'd9) | (B > 4'd9);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= 4'd0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            err_q  <= err_d;
        end
    end

    assign Sum  = sum_q;
    assign Cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_adder.sv
// Directed and exhaustive bench for the registered single-digit BCD adder.
module tb_bcd_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic [3:0] Sum;
    logic       Cout;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_adder dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .Sum  (Sum),
        .Cout (Cout),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int exp_sum, input int exp_cout, input int exp_err);
        check_val({tag, ".sum"},  int'(Sum),  exp_sum);
        check_val({tag, ".cout"}, int'(Cout), exp_cout);
        check_val({tag, ".err"},  int'(err),  exp_err);
    endtask

    // Drive one vector, let one edge capture it, then sample just after the edge.
    task automatic apply(input int a, input int b, input int c, input string tag,
                         input int exp_sum, input int exp_cout, input int exp_err);
        A   = 4'(a);
        B   = 4'(b);
        Cin = 1'(c);
        @(posedge clk);
        #1;
        check_out(tag, exp_sum, exp_cout, exp_err);
    endtask

    initial begin
        rst_n = 1'b0;
        A     = 4'd9;
        B     = 4'd9;
        Cin   = 1'b1;
        #1;

        // Reset held for two edges with the max valid operands applied.
        @(posedge clk); #1;
        check_out("rst0", 0, 0, 0);
        @(posedge clk); #1;
        check_out("rst1", 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_out("rst_release", 9, 1, 0);

        // Directed sequence.
        apply(6, 9, 0, "d_6_9_0", 5, 1, 0);
        apply(3, 3, 1, "d_3_3_1", 7, 0, 0);
        apply(4, 5, 0, "d_4_5_0", 9, 0, 0);
        apply(8, 2, 0, "d_8_2_0", 0, 1, 0);
        apply(9, 9, 1, "d_9_9_1", 9, 1, 0);

        // Boundaries around the correction threshold.
        apply(0, 0, 0, "b_0_0_0", 0, 0, 0);
        apply(5, 4, 0, "b_5_4_0", 9, 0, 0);
        apply(5, 4, 1, "b_5_4_1", 0, 1, 0);
        apply(0, 9, 1, "b_0_9_1", 0, 1, 0);

        // Outputs must hold while inputs move mid-cycle.
        A = 4'd1; B = 4'd2; Cin = 1'b0;
        #3;
        check_out("hold", 0, 1, 0);

        // Non-BCD operands.
        apply(12, 3, 0, "inv_12_3_0", 5, 1, 1);
        apply(15, 15, 1, "inv_15_15_1", 5, 1, 1);
        apply(3, 12, 1, "inv_3_12_1", 6, 1, 1);
        apply(2, 2, 0, "inv_recover", 4, 0, 0);

        // Reset on the same edge as an in-flight vector.
        A = 4'd7; B = 4'd8; Cin = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        check_out("rst_mid", 0, 0, 0);
        rst_n = 1'b1;
        apply(7, 8, 0, "after_rst_mid", 5, 1, 0);

        // Exhaustive valid sweep against the decimal reference.
        for (int a = 0; a < 10; a++) begin
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < 2; c++) begin
                    int total;
                    total = a + b + c;
                    apply(a, b, c, $sformatf("sw_%0d_%0d_%0d", a, b, c),
                          total % 10, total / 10, 0);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
